mac_pe_param: RTL

//  Parametrised systolic processing element, successor to the fixed 8/8/24 MAC cell.

---
 rtl/mac_pkg.sv | 41 ++++
 rtl/mac_acc_add.sv | 32 +++
 rtl/mac_pe_param.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/mac_pkg.sv
// ---------------------------------------------------------------------------
// mac_pkg
// Shared definitions for the parametrised MAC processing element.
//   mode_e      : dataflow mode (MODE_OS = output-stationary, MODE_WS = weight-stationary)
//   *_W_DEF     : default operand / accumulator widths
//   sat_add()   : signed add clamped to a 'width'-bit two's complement range;
//                 operands are passed sign-extended to SAT_XW bits (width < 63)
// ---------------------------------------------------------------------------
package mac_pkg;

    typedef enum logic {
        MODE_OS = 1'b0,
        MODE_WS = 1'b1
    } mode_e;

    localparam int unsigned A_W_DEF   = 8;
    localparam int unsigned W_W_DEF   = 8;
    localparam int unsigned ACC_W_DEF = 24;

    localparam int unsigned SAT_XW = 64;

    function automatic logic signed [SAT_XW-1:0] sat_add(
        input logic signed [SAT_XW-1:0] a,
        input logic signed [SAT_XW-1:0] b,
        input int unsigned              width
    );
        logic signed [SAT_XW-1:0] s;
        logic signed [SAT_XW-1:0] hi;
        s  = a + b;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        // ~hi is the most negative value of the target width
        if (s > hi) begin
            return hi;
        end
        if (s < ~hi) begin
            return ~hi;
        end
        return s;
    endfunction

endpackage

// File: rtl/mac_acc_add.sv
// ---------------------------------------------------------------------------
// mac_acc_add
// Stage-2 adder of the MAC PE, shared by the OS accumulate and WS psum paths.
//   a, b  in  ACC_W  signed addends
//   sum   out ACC_W  a + b (wraps; saturates when MAC_PE_SAT_EN is defined)
//   ovf   out 1      the exact sum does not fit in ACC_W signed bits
// ---------------------------------------------------------------------------
module mac_acc_add
    import mac_pkg::*;
#(
    parameter int unsigned ACC_W = ACC_W_DEF
) (
    input  logic [ACC_W-1:0] a,
    input  logic [ACC_W-1:0] b,
    output logic [ACC_W-1:0] sum,
    output logic             ovf
);

    logic [ACC_W-1:0] raw;

    always_comb begin
        raw = a + b;
        // signed overflow: like-signed addends producing an opposite-signed result
        ovf = (a[ACC_W-1] == b[ACC_W-1]) && (raw[ACC_W-1] != a[ACC_W-1]);
`ifdef MAC_PE_SAT_EN
        sum = ACC_W'(sat_add(SAT_XW'(signed'(a)), SAT_XW'(signed'(b)), ACC_W));
`else
        sum = raw;
`endif
    end

endmodule

// File: rtl/mac_pe_param.sv
// ---------------------------------------------------------------------------
// mac_pe_param
// Parametrised systolic MAC processing element, 2-stage pipeline.
//   OS mode: products accumulate locally; clear_i dumps and restarts the acc.
//   WS mode: a held weight multiplies act_in; psum_in is added, result flows south.
// Configuration macro: MAC_PE_SAT_EN -- saturating stage-2 add plus sticky sat_o.
// Ports:
//   clk, rst_n           clock (rising), asynchronous active-low reset
//   mode_i               0 = OS, 1 = WS (quasi-static)
//   clear_i              OS only: dump and zero the accumulator
//   act_in/act_valid_in  activation from west and its qualifier
//   wgt_in/wgt_load_in   weight from north; load strobe for the weight register
//   psum_in              WS partial sum from north, aligned with act_in
//   act_out/act_valid_out, wgt_out   1-cycle registered pass-through
//   psum_out/psum_valid_out          result and qualifier
//   sat_o                sticky overflow flag (MAC_PE_SAT_EN only)
// ACC_W must be >= A_W + W_W and below 63.
// ---------------------------------------------------------------------------
module mac_pe_param
    import mac_pkg::*;
#(
    parameter int unsigned A_W   = A_W_DEF,
    parameter int unsigned W_W   = W_W_DEF,
    parameter int unsigned ACC_W = ACC_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mode_i,
    input  logic             clear_i,
    input  logic [A_W-1:0]   act_in,
    input  logic             act_valid_in,
    input  logic [W_W-1:0]   wgt_in,
    input  logic             wgt_load_in,
    input  logic [ACC_W-1:0] psum_in,
    output logic [A_W-1:0]   act_out,
    output logic             act_valid_out,
    output logic [W_W-1:0]   wgt_out,
    output logic [ACC_W-1:0] psum_out,
    output logic             psum_valid_out
`ifdef MAC_PE_SAT_EN
    ,
    output logic             sat_o
`endif
);

    localparam int unsigned P_W = A_W + W_W;

    mode_e                  mode_in;
    mode_e                  mode_q;
    logic                   mode_chg;
    logic [W_W-1:0]         wgt_reg;
    logic [W_W-1:0]         wgt_op;
    logic signed [P_W-1:0]  prod_d;
    logic signed [P_W-1:0]  prod_q;
    logic [ACC_W-1:0]       prod_ext;
    logic [ACC_W-1:0]       psum_q;
    logic                   v1_q;
    logic [ACC_W-1:0]       acc;
    logic [ACC_W-1:0]       add_a;
    logic [ACC_W-1:0]       add_sum;
    logic                   add_ovf;

    always_comb begin
        mode_in  = mode_e'(mode_i);
        mode_chg = (mode_in != mode_q);
        // wgt_reg is read before any same-cycle load lands
        wgt_op   = (mode_in == MODE_WS) ? wgt_reg : wgt_in;
        prod_d   = P_W'(signed'(act_in)) * P_W'(signed'(wgt_op));
        prod_ext = ACC_W'(prod_q);
        add_a    = (mode_q == MODE_WS) ? psum_q : acc;
    end

    mac_acc_add #(
        .ACC_W (ACC_W)
    ) u_add (
        .a   (add_a),
        .b   (prod_ext),
        .sum (add_sum),
        .ovf (add_ovf)
    );

    // Stage 1: pass-through registers, weight register, product capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_out       <= '0;
            act_valid_out <= 1'b0;
            wgt_out       <= '0;
            wgt_reg       <= '0;
            prod_q        <= '0;
            psum_q        <= '0;
            v1_q          <= 1'b0;
            mode_q        <= MODE_OS;
        end else begin
            act_out       <= act_in;
            act_valid_out <= act_valid_in;
            wgt_out       <= wgt_in;
            if (wgt_load_in) begin
                wgt_reg <= wgt_in;
            end
            prod_q <= prod_d;
            psum_q <= psum_in;
            // a product formed while the mode flips belongs to neither mode
            v1_q   <= act_valid_in & ~mode_chg;
            mode_q <= mode_in;
        end
    end

    // Stage 2: psum_out is a registered image of the accumulator in OS,
    // except on a clear edge where it carries the pre-clear value once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc            <= '0;
            psum_out       <= '0;
            psum_valid_out <= 1'b0;
        end else if (mode_chg) begin
            acc            <= '0;
            psum_out       <= '0;
            psum_valid_out <= 1'b0;
        end else if (mode_q == MODE_OS) begin
            if (clear_i) begin
                psum_out       <= acc;
                psum_valid_out <= 1'b1;
                acc            <= v1_q ? prod_ext : '0;
            end else begin
                psum_valid_out <= 1'b0;
                if (v1_q) begin
                    acc      <= add_sum;
                    psum_out <= add_sum;
                end else begin
                    psum_out <= acc;
                end
            end
        end else begin
            psum_valid_out <= v1_q;
            if (v1_q) begin
                psum_out <= add_sum;
            end
        end
    end

`ifdef MAC_PE_SAT_EN
    logic sat_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_q <= 1'b0;
        end else if (!mode_chg) begin
            if ((mode_q == MODE_OS) && clear_i) begin
                sat_q <= 1'b0;
            end else if (v1_q && add_ovf) begin
                sat_q <= 1'b1;
            end
        end
    end

    always_comb begin
        sat_o = sat_q;
    end
`else
    logic unused_ovf;

    always_comb begin
        unused_ovf = add_ovf;
    end
`endif

endmodule
